// File: rtl/data_mem_responder.sv
// data_mem_responder
//   Far end of the MEM-stage memRead/memWrite/mode request interface. Services
//   word and byte loads/stores against an internal 32-bit word array with a
//   fixed access latency, holding the pipeline via stall until the access is
//   complete.
//
// Ports
//   clk         rising-edge clock
//   reset       asynchronous, active-high reset (array contents are kept)
//   mem_read    load request, held by the pipeline while stalled
//   mem_write   store request, held by the pipeline while stalled (wins over read)
//   mode        access size: 0 = word, 1 = byte
//   addr        byte address; only addr[ADDR_WIDTH+1:0] is used (wraps)
//   wdata       store data; byte stores use wdata[7:0]
//   rdata       load result, held until the next load completes
//   done        one-cycle pulse when an access completes
//   misaligned  one-cycle pulse with done for a word access with addr[1:0]!=0
//   stall       combinational pipeline hold request
module data_mem_responder #(
  parameter int ADDR_WIDTH = 10,
  parameter int LATENCY    = 2
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        mem_read,
  input  logic        mem_write,
  input  logic        mode,
  input  logic [31:0] addr,
  input  logic [31:0] wdata,
  output logic [31:0] rdata,
  output logic        done,
  output logic        misaligned,
  output logic        stall
);

  localparam int DEPTH = 2 ** ADDR_WIDTH;
  // Counter only needs to hold LATENCY-1; keep at least one bit for LATENCY=1.
  localparam int CNT_W = (LATENCY > 1) ? $clog2(LATENCY) : 1;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t                 state;
  logic [CNT_W-1:0]       cnt;
  logic [ADDR_WIDTH-1:0]  idx_q;
  logic [1:0]             lane_q;
  logic [31:0]            wdata_q;
  logic                   mode_q;
  logic                   write_q;

  logic [31:0]            mem [DEPTH];

  logic                   req;
  logic                   access_now;
  logic                   bad_align;
  logic [31:0]            cur_word;
  logic [7:0]             cur_byte;
  logic [31:0]            merged_word;
  logic [31:0]            load_value;

  // Upper address bits are deliberately ignored so addresses wrap.
  logic unused_addr;
  assign unused_addr = ^addr[31:ADDR_WIDTH+2];

  assign req        = mem_read | mem_write;
  assign access_now = (state == BUSY) && (cnt == '0);
  assign bad_align  = !mode_q && (lane_q != 2'b00);
  assign cur_word   = mem[idx_q];

  // Stall is forced low while reset is held so the pipeline sees a clean IDLE.
  assign stall = !reset && (((state == IDLE) && req) || (state == BUSY));

  // Little-endian lane select and byte merge for the latched address.
  always_comb begin
    cur_byte    = cur_word[7:0];
    merged_word = cur_word;
    case (lane_q)
      2'd0: begin
        cur_byte          = cur_word[7:0];
        merged_word[7:0]  = wdata_q[7:0];
      end
      2'd1: begin
        cur_byte          = cur_word[15:8];
        merged_word[15:8] = wdata_q[7:0];
      end
      2'd2: begin
        cur_byte           = cur_word[23:16];
        merged_word[23:16] = wdata_q[7:0];
      end
      default: begin
        cur_byte           = cur_word[31:24];
        merged_word[31:24] = wdata_q[7:0];
      end
    endcase
  end

  // Value loaded into rdata: misaligned word reads return zero, byte reads
  // are zero-extended (sign extension happens downstream).
  always_comb begin
    load_value = cur_word;
    if (bad_align) begin
      load_value = 32'h0;
    end else if (mode_q) begin
      load_value = {24'h0, cur_byte};
    end
  end

  // Control FSM: latch request in IDLE, count out the latency in BUSY, pulse
  // done for one cycle in DONE. Requests seen in DONE belong to the same
  // instruction and are ignored.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state      <= IDLE;
      cnt        <= '0;
      rdata      <= 32'h0;
      done       <= 1'b0;
      misaligned <= 1'b0;
      idx_q      <= '0;
      lane_q     <= 2'b00;
      wdata_q    <= 32'h0;
      mode_q     <= 1'b0;
      write_q    <= 1'b0;
    end else begin
      done       <= 1'b0;
      misaligned <= 1'b0;
      case (state)
        IDLE: begin
          if (req) begin
            idx_q   <= addr[ADDR_WIDTH+1:2];
            lane_q  <= addr[1:0];
            wdata_q <= wdata;
            mode_q  <= mode;
            write_q <= mem_write;
            cnt     <= CNT_W'(LATENCY - 1);
            state   <= BUSY;
          end
        end
        BUSY: begin
          if (cnt != '0) begin
            cnt <= cnt - CNT_W'(1);
          end else begin
            state      <= DONE;
            done       <= 1'b1;
            misaligned <= bad_align;
            if (!write_q) begin
              rdata <= load_value;
            end
          end
        end
        DONE: begin
          state <= IDLE;
        end
        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

  // Array update on the edge entering DONE. The array has no reset; an
  // aborted access never reaches this point because reset returns to IDLE.
  always_ff @(posedge clk) begin
    if (!reset && access_now && write_q && !bad_align) begin
      mem[idx_q] <= mode_q ? merged_word : wdata_q;
    end
  end

endmodule
